// File: rtl/de4_qsys_led_pwm_pkg.sv
// Shared register map and bus request type for the LED PWM slave.
package de4_qsys_led_pwm_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_PERIOD = 2'd3;

  // readdata bit carrying the live blink phase on the PERIOD word
  localparam int PHASE_BIT = 31;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } av_req_t;

endpackage

// File: rtl/de4_qsys_led_pwm_timebase.sv
// Free-running prescaler -> PWM counter -> blink counter chain.
module de4_qsys_led_pwm_timebase #(
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 1,
  parameter int BLINK_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [BLINK_BITS-1:0] period,
  input  logic                  period_load,
  output logic [PWM_BITS-1:0]   pwm_cnt,
  output logic                  pwm_wrap,
  output logic                  blink_phase
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]       ps_cnt;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  tick;

  assign tick     = (ps_cnt == PS_W'(PRESCALE - 1));
  assign pwm_wrap = tick && (pwm_cnt == '1);

  // prescaler: 0..PRESCALE-1, wraps on tick (stays 0 when PRESCALE=1)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + 1'b1;
  end

  // PWM counter advances once per tick, natural wrap at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 1'b1;
  end

  // blink counter: a PERIOD load restarts the cycle and beats a concurrent toggle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (period_load || period == '0) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (pwm_wrap) begin
      if (blink_cnt == period - BLINK_BITS'(1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/de4_qsys_led_pwm.sv
// Avalon-MM LED driver: per-bit enable, global PWM brightness, masked blink.
module de4_qsys_led_pwm
  import de4_qsys_led_pwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 1,
  parameter int BLINK_BITS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  av_req_t               req;
  logic [WIDTH-1:0]      data_r, mask_r;
  logic [PWM_BITS-1:0]   duty_r, pwm_cnt;
  logic [BLINK_BITS-1:0] period_r;
  logic                  pwm_wrap, blink_phase, pwm_on, period_load;

  assign req.wr    = chipselect && !write_n;
  assign req.addr  = address;
  assign req.wdata = writedata;

  assign period_load = req.wr && (req.addr == ADDR_PERIOD);

  de4_qsys_led_pwm_timebase #(
    .PWM_BITS   (PWM_BITS),
    .PRESCALE   (PRESCALE),
    .BLINK_BITS (BLINK_BITS)
  ) u_tb (
    .clk         (clk),
    .reset_n     (reset_n),
    .period      (period_r),
    .period_load (period_load),
    .pwm_cnt     (pwm_cnt),
    .pwm_wrap    (pwm_wrap),
    .blink_phase (blink_phase)
  );

  // register file writes; unused writedata MSBs dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r   <= '0;
      duty_r   <= '1;
      mask_r   <= '0;
      period_r <= '0;
    end else if (req.wr) begin
      case (req.addr)
        ADDR_DATA:   data_r   <= req.wdata[WIDTH-1:0];
        ADDR_DUTY:   duty_r   <= req.wdata[PWM_BITS-1:0];
        ADDR_MASK:   mask_r   <= req.wdata[WIDTH-1:0];
        default:     period_r <= req.wdata[BLINK_BITS-1:0];
      endcase
    end
  end

  // readback mux, zero-filled, independent of chipselect
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0]    = data_r;
      ADDR_DUTY: readdata[PWM_BITS-1:0] = duty_r;
      ADDR_MASK: readdata[WIDTH-1:0]    = mask_r;
      default: begin
        readdata[BLINK_BITS-1:0] = period_r;
        readdata[PHASE_BIT]      = blink_phase;
      end
    endcase
  end

  // all-ones duty forces on so full brightness has no dark slot
  assign pwm_on = (duty_r == '1) || (pwm_cnt < duty_r);

  // output register: enable & brightness & (unmasked or blink-on)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= '0;
    else          out_port <= data_r & {WIDTH{pwm_on}} & (~mask_r | {WIDTH{blink_phase}});
  end

endmodule

// File: tb/tb_de4_qsys_led_pwm.sv
// Directed bench: three instances (default, 4-bit PWM /1, 4-bit PWM /2) on a shared bus.
module tb_de4_qsys_led_pwm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic        cs_a = 1'b0, cs_b = 1'b0, cs_c = 1'b0;
  logic [31:0] rd_a, rd_b, rd_c;
  logic [7:0]  out_a, out_b, out_c;
  int          vec = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  de4_qsys_led_pwm dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .out_port(out_a));

  de4_qsys_led_pwm #(.PWM_BITS(4), .PRESCALE(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b), .out_port(out_b));

  de4_qsys_led_pwm #(.PWM_BITS(4), .PRESCALE(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_c),
    .write_n(write_n), .writedata(writedata), .readdata(rd_c), .out_port(out_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive a write starting at the current negedge; returns one negedge later
  task automatic wr_now(input int which, input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write_n = 1'b0;
    cs_a = (which == 0); cs_b = (which == 1); cs_c = (which == 2);
    @(negedge clk);
    write_n = 1'b1; cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
  endtask

  task automatic wr(input int which, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_now(which, a, d);
  endtask

  // negedges until out_c[1] changes, bounded at 200
  task automatic wait_toggle(output int n);
    logic p;
    p = out_c[1];
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (out_c[1] !== p) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp33 [4];
    int n, hi, bad;
    exp33[0] = 32'h0; exp33[1] = 32'hFF; exp33[2] = 32'h0; exp33[3] = 32'h8000_0000;

    // reset defaults
    repeat (3) @(negedge clk);
    check("out_in_reset", {24'd0, out_a}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      address = 2'(i);
      #1;
      check($sformatf("reset_rd%0d", i), rd_a, exp33[i]);
    end
    address = 2'd1; #1;
    check("reset_duty_4b", rd_b, 32'hF);
    check("reset_out", {24'd0, out_a}, 32'h0);

    // full duty; upper writedata bits ignored
    wr(0, 2'd0, 32'h1234_56A5);
    check("data_lat1", {24'd0, out_a}, 32'h0);
    address = 2'd0; #1;
    check("data_rd", rd_a, 32'hA5);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_a !== 8'hA5) bad++;
    end
    check("full_duty_steady_bad", bad, 0);

    // DUTY=0 -> dark
    wr(0, 2'd1, 32'h0);
    wr(0, 2'd0, 32'hFF);
    address = 2'd1; #1;
    check("duty0_rd", rd_a, 32'h0);
    bad = 0;
    repeat (64) begin
      @(negedge clk);
      if (out_a !== 8'h00) bad++;
    end
    check("duty0_dark_bad", bad, 0);

    // partial duty 4/16
    wr(1, 2'd0, 32'h1);
    wr(1, 2'd1, 32'h4);
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      hi = 0; bad = 0;
      repeat (16) begin
        @(negedge clk);
        hi += int'(out_b[0]);
        if (out_b[7:1] !== 7'd0) bad++;
      end
      check($sformatf("pwm4_win%0d_high", w), hi, 4);
      check($sformatf("pwm4_win%0d_upper", w), bad, 0);
    end

    // blinking: 32 clk per PWM frame, 3 frames per phase
    wr(2, 2'd0, 32'h3);
    wr(2, 2'd2, 32'h2);
    wr(2, 2'd3, 32'h3);
    address = 2'd3; #1;
    check("blink_start_phase", rd_c, 32'h8000_0003);
    wait_toggle(n);
    check("blink_first_toggle_seen", 32'(n < 200), 32'h1);
    check("blink_phase_track0", {31'd0, rd_c[31]}, {31'd0, out_c[1]});
    for (int k = 0; k < 3; k++) begin
      bad = 0;
      wait_toggle(n);
      check($sformatf("blink_interval%0d", k), n, 96);
      check($sformatf("blink_phase_track%0d", k + 1), {31'd0, rd_c[31]}, {31'd0, out_c[1]});
      check($sformatf("blink_bit0_%0d", k), {31'd0, out_c[0]}, 32'h1);
    end
    check("blink_rose_last", {31'd0, out_c[1]}, 32'h1);

    // PERIOD write landing on the toggling wrap: load wins
    repeat (94) @(negedge clk);
    wr_now(2, 2'd3, 32'h3);
    #1;
    check("period_vs_toggle_phase", {31'd0, rd_c[31]}, 32'h1);
    wait_toggle(n);
    check("period_reload_interval", n, 97);

    // PERIOD=0 disables blinking, bit1 held on
    wr(2, 2'd3, 32'h0);
    @(negedge clk);
    address = 2'd3; #1;
    check("period0_rd", rd_c, 32'h8000_0000);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (out_c !== 8'h03) bad++;
    end
    check("period0_steady_bad", bad, 0);

    // asynchronous reset mid-blink
    wr(0, 2'd1, 32'hFF);
    wr(2, 2'd3, 32'h3);
    repeat (50) @(negedge clk);
    check("pre_reset_out_a", {24'd0, out_a}, 32'hFF);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out_a", {24'd0, out_a}, 32'h0);
    check("async_rst_out_c", {24'd0, out_c}, 32'h0);
    address = 2'd3; #1;
    check("async_rst_period_c", rd_c, 32'h8000_0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_a", {24'd0, out_a}, 32'h0);
    check("post_rst_out_c", {24'd0, out_c}, 32'h0);
    address = 2'd1; #1;
    check("post_rst_duty_b", rd_b, 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/de4_qsys_led_pwm.md
DE4_QSYS_LED_PWM -- requirements
Module: de4_qsys_led_pwm

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of output bits, legal 1..32.
REQ-002 SHALL have parameter PWM_BITS, default 8: width of the PWM counter and duty register, legal 1..16.
REQ-003 SHALL have parameter PRESCALE, default 1: clk cycles per PWM tick, legal >=1.
REQ-004 SHALL have parameter BLINK_BITS, default 16: width of the blink period register, legal 1..31.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state is clocked on the rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port address, input, 2 bits: Avalon-MM slave word address.
REQ-008 SHALL have port chipselect, input, 1 bit: slave select.
REQ-009 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-010 SHALL have port writedata, input, 32 bits: write data.
REQ-011 SHALL have port readdata, output, 32 bits: read data; combinational, zero wait states, read latency 0.
REQ-012 SHALL have port out_port, output, WIDTH bits: registered LED drive.

Function
REQ-013 SHALL decode a write as chipselect=1 and write_n=0, taking effect on the next clk edge; unused writedata MSBs are ignored.
REQ-014 SHALL implement address 0 as DATA[WIDTH-1:0] (rw): the per-bit LED enable.
REQ-015 SHALL implement address 1 as DUTY[PWM_BITS-1:0] (rw): the global brightness.
REQ-016 SHALL implement address 2 as BLINK_MASK[WIDTH-1:0] (rw): the bits subject to blinking.
REQ-017 SHALL implement address 3 as PERIOD[BLINK_BITS-1:0] (rw), with readdata[31] returning the read-only blink_phase.
REQ-018 SHALL zero-fill all unused readdata bits.
REQ-019 SHALL run a prescaler counting 0..PRESCALE-1 and assert tick for one clk when it reaches PRESCALE-1, then wrap to 0; with PRESCALE=1, tick is asserted every cycle.
REQ-020 SHALL increment pwm_cnt (PWM_BITS wide) on each tick, wrapping at all-ones to 0; pwm_wrap is defined as tick with pwm_cnt all-ones.
REQ-021 SHALL compute pwm_on = (DUTY == all-ones) OR (pwm_cnt < DUTY), so that DUTY=0 is always off and DUTY=max is always on.
REQ-022 SHALL increment blink_cnt (BLINK_BITS wide) on each pwm_wrap while PERIOD != 0; when blink_cnt == PERIOD-1 on a pwm_wrap, it SHALL toggle blink_phase and clear blink_cnt.
REQ-023 SHALL hold blink_phase=1 and blink_cnt=0 while PERIOD == 0, which disables blinking.
REQ-024 SHALL, on a write to PERIOD, clear blink_cnt and set blink_phase=1 in the same edge, overriding any concurrent toggle.
REQ-025 SHALL register out_port[i] <= DATA[i] & pwm_on & (~BLINK_MASK[i] | blink_phase), giving 1 clk latency from any state change to the output.
REQ-026 SHALL not reset or stall the prescaler or pwm_cnt on register writes; a new DUTY applies on the next compare.
REQ-027 SHALL return readdata as a pure function of address and the current registers, independent of chipselect.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously force DATA=0, DUTY=all-ones, BLINK_MASK=0, PERIOD=0, prescaler=0, pwm_cnt=0, blink_cnt=0, blink_phase=1, and out_port=0.
REQ-029 SHALL, after reset deasserts mid-operation, update out_port on the first clk edge (to 0 while DATA=0), with all counters restarting from 0.

Structure
REQ-030 SHALL place the register address constants (ADDR_DATA=0, ADDR_DUTY=1, ADDR_MASK=2, ADDR_PERIOD=3) and the readdata phase bit index (31) in shared package de4_qsys_led_pwm_pkg.
REQ-031 SHALL implement the prescaler, PWM counter, and blink counter in one sub-module, de4_qsys_led_pwm_timebase, which outputs pwm_cnt, pwm_wrap, and blink_phase and accepts a period_load strobe.
REQ-032 SHALL keep the Avalon decode, registers, readback mux, and output register in the top module.

Verification
REQ-033 SHALL cover reset defaults: with reset released, read addresses 0..3 -> 0x0, 0xFF, 0x0, 0x80000000 (WIDTH=8, PWM_BITS=8); out_port=0.
REQ-034 SHALL cover full duty: write DATA=0xA5 with DUTY at its default 0xFF -> out_port=0xA5 steady from the 2nd edge after the write.
REQ-035 SHALL cover partial duty: with PWM_BITS=4, PRESCALE=1, DATA=0x01, and DUTY=4 -> out_port[0] high for exactly 4 of every 16 clks, repeating.
REQ-036 SHALL cover DUTY=0: with DATA=0xFF and DUTY=0 -> out_port=0 for at least 64 clks.
REQ-037 SHALL cover blinking: with PWM_BITS=4, PRESCALE=2, DATA=0x03, BLINK_MASK=0x02, and PERIOD=3 -> bit1 toggles every 96 clks and bit0 stays high; readdata[31] tracks the phase.
REQ-038 SHALL cover a PERIOD write coinciding with a toggle pwm_wrap -> blink_phase=1 and blink_cnt=0; then disable with PERIOD=0 -> bit1 stays high; finally assert reset_n=0 mid-blink -> out_port=0 asynchronously.
